// File: rtl/trees_ctrl.sv
// trees_ctrl: sequencer for the tree-ensemble inference engine.
//
// A job is requested on the cfg handshake. The model (N_TREES x N_NODE_AND_LEAFS
// node words) is written into the engine first if the job asks for it. Then, for
// every sample, N_FEATURE/2 feature-pair words are written, start is pulsed, the
// engine's done pulse is awaited, and the prediction is returned on the output
// stream. A one-cycle job_done pulse closes the job.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid is held and its data kept stable until that edge.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_valid/cfg_ready           job request handshake; cfg_ready high only in idle
//   cfg_load_model, cfg_n_samples job fields, latched on the cfg handshake
//   job_done                      one-cycle pulse at the end of a job
//   in_valid/in_ready/in_data     64-bit input stream (node words or feature pairs)
//   out_valid/out_ready/out_data  32-bit prediction stream
//   load_trees,n_tree,n_node,tree_nodes    engine node write port (registered)
//   load_features,n_feature,features2      engine feature write port (registered)
//   start, prediction, done       engine control/result
//   fsm_state                     debug view of the sequencer state
module trees_ctrl #(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic                                cfg_load_model,
  input  logic [31:0]                         cfg_n_samples,
  output logic                                job_done,
  input  logic                                in_valid,
  input  logic [63:0]                         in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [31:0]                         out_data,
  input  logic                                out_ready,
  output logic                                load_trees,
  output logic [$clog2(N_TREES)-1:0]          n_tree,
  output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
  output logic [63:0]                         tree_nodes,
  output logic                                load_features,
  output logic [31:0]                         n_feature,
  output logic [63:0]                         features2,
  output logic                                start,
  input  logic [31:0]                         prediction,
  input  logic                                done,
  output logic [2:0]                          fsm_state
);

  localparam int TW          = $clog2(N_TREES);
  localparam int NW          = $clog2(N_NODE_AND_LEAFS);
  localparam int MODEL_WORDS = N_TREES * N_NODE_AND_LEAFS;
  localparam int FEAT_WORDS  = N_FEATURE / 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_MODEL = 3'd1,
    S_LD_FEAT  = 3'd2,
    S_START    = 3'd3,
    S_WAIT     = 3'd4,
    S_OUT      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      state;
  logic [31:0] remaining;
  logic [31:0] in_cnt;
  logic        in_fire;

  assign in_fire   = in_valid && in_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cfg_ready     <= 1'b1;
      job_done      <= 1'b0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      load_trees    <= 1'b0;
      n_tree        <= '0;
      n_node        <= '0;
      tree_nodes    <= '0;
      load_features <= 1'b0;
      n_feature     <= '0;
      features2     <= '0;
      start         <= 1'b0;
      remaining     <= '0;
      in_cnt        <= '0;
    end else begin
      load_trees    <= 1'b0;
      load_features <= 1'b0;
      start         <= 1'b0;
      job_done      <= 1'b0;

      // Index outputs describe the word being strobed this cycle; they move on
      // once that strobe has been written, so after the last node word both
      // indices read 0 again.
      if (load_trees) begin
        if (n_node == NW'(N_NODE_AND_LEAFS - 1)) begin
          n_node <= '0;
          n_tree <= (n_tree == TW'(N_TREES - 1)) ? '0 : n_tree + TW'(1);
        end else begin
          n_node <= n_node + NW'(1);
        end
      end
      if (load_features) n_feature <= n_feature + 32'd2;

      case (state)
        S_IDLE: begin
          // cfg_ready comes back the cycle after the job_done pulse.
          if (job_done) begin
            cfg_ready <= 1'b1;
          end else if (cfg_valid && cfg_ready) begin
            cfg_ready <= 1'b0;
            remaining <= cfg_n_samples;
            in_cnt    <= '0;
            if (cfg_load_model) begin
              state    <= S_LD_MODEL;
              in_ready <= 1'b1;
            end else if (cfg_n_samples != 32'd0) begin
              state    <= S_LD_FEAT;
              in_ready <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_LD_MODEL: begin
          if (in_fire) begin
            load_trees <= 1'b1;
            tree_nodes <= in_data;
            if (in_cnt == 32'(MODEL_WORDS - 1)) begin
              in_cnt <= '0;
              if (remaining != 32'd0) begin
                state <= S_LD_FEAT;
              end else begin
                state    <= S_DONE;
                in_ready <= 1'b0;
              end
            end else begin
              in_cnt <= in_cnt + 32'd1;
            end
          end
        end
        S_LD_FEAT: begin
          if (in_fire) begin
            load_features <= 1'b1;
            features2     <= in_data;
            if (in_cnt == 32'(FEAT_WORDS - 1)) begin
              in_cnt   <= '0;
              in_ready <= 1'b0;
              state    <= S_START;
            end else begin
              in_cnt <= in_cnt + 32'd1;
            end
          end
        end
        S_START: begin
          // The last feature strobe is on the port during this cycle, so start
          // lands one cycle after it.
          start <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          n_feature <= '0;
          // A done coinciding with our own start pulse cannot belong to it.
          if (done && !start) begin
            out_data  <= prediction;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - 32'd1;
            if (remaining > 32'd1) begin
              state    <= S_LD_FEAT;
              in_ready <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          job_done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trees_ctrl.sv
// Testbench for trees_ctrl: drivers for cfg/input streams, a behavioural engine
// model, and a negedge monitor that checks engine writes, start timing and the
// prediction stream against expected queues.
module tb_trees_ctrl;
  localparam int N_TREES     = 16;
  localparam int N_NODES     = 256;
  localparam int N_FEATURE   = 32;
  localparam int MODEL_WORDS = N_TREES * N_NODES;
  localparam int FEAT_WORDS  = N_FEATURE / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_load_model = 1'b0;
  logic [31:0] cfg_n_samples = '0;
  logic        job_done;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        load_trees;
  logic [3:0]  n_tree;
  logic [7:0]  n_node;
  logic [63:0] tree_nodes;
  logic        load_features;
  logic [31:0] n_feature;
  logic [63:0] features2;
  logic        start;
  logic [31:0] prediction = '0;
  logic        done = 1'b0;
  logic [2:0]  fsm_state;

  trees_ctrl #(.N_TREES(N_TREES), .N_NODE_AND_LEAFS(N_NODES), .N_FEATURE(N_FEATURE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_load_model(cfg_load_model),
    .cfg_n_samples(cfg_n_samples), .job_done(job_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node), .tree_nodes(tree_nodes),
    .load_features(load_features), .n_feature(n_feature), .features2(features2),
    .start(start), .prediction(prediction), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // ---------------- scoreboard queues ----------------
  logic [75:0] node_q[$];  // {tree, node, word}
  logic [95:0] feat_q[$];  // {feature index, pair}
  logic [31:0] exp_q[$];   // predictions expected on the output stream
  logic [31:0] pred_q[$];  // predictions the engine model will return

  // ---------------- engine model ----------------
  int eng_cnt  = 0;
  bit eng_hold = 1'b0;
  int inj_req  = 0;
  int inj_seen = 0;
  always @(posedge clk) begin
    #1;
    done = 1'b0;
    if (!rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          done = 1'b1;
          if (pred_q.size() > 0) prediction = pred_q.pop_front();
          else chk("engine_pred_available", 0, 1);
        end
      end
      if (inj_req != inj_seen) begin
        inj_seen   = inj_req;
        done       = 1'b1;
        prediction = 32'hdead_beef;
      end
      if (start && !eng_hold) eng_cnt = $urandom_range(1, 4);
    end
  end

  // ---------------- output sink ----------------
  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // ---------------- monitor ----------------
  bit          held = 1'b0;
  logic [31:0] held_data = '0;
  int          last_feat_cyc = -100;
  int          n_start = 0;
  int          n_job_done = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (load_trees) begin
        if (node_q.size() == 0) chk("node_write_expected", 0, 1);
        else chk("node_write", {n_tree, n_node, tree_nodes}, node_q.pop_front());
      end
      if (load_features) begin
        last_feat_cyc = cyc;
        if (feat_q.size() == 0) chk("feature_write_expected", 0, 1);
        else chk("feature_write", {n_feature, features2}, feat_q.pop_front());
      end
      if (start) begin
        n_start++;
        chk("start_after_last_feature", cyc - last_feat_cyc, 1);
      end
      if (held) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, held_data);
      end
      held = 1'b0;
      if (out_valid) begin
        chk("engine_quiet_while_out", {start, load_trees, load_features}, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("out_valid_expected", 0, 1);
          else chk("out_data", out_data, exp_q.pop_front());
        end else begin
          held      = 1'b1;
          held_data = out_data;
        end
      end
      if (job_done) n_job_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {cfg_ready, in_ready, out_valid, job_done, load_trees, load_features, start}, 7'b1000000);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_node_port"}, {n_tree, n_node, tree_nodes}, 0);
    chk({tag, "_feat_port"}, {n_feature, features2}, 0);
    chk({tag, "_state_idle"}, fsm_state, 0);
  endtask

  task automatic send_cfg(input bit load, input int unsigned n);
    int t = 0;
    while (!cfg_ready && t < 200) begin tick(1); t++; end
    chk("cfg_ready_before_request", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_load_model = load; cfg_n_samples = n;
    tick(1);
    cfg_valid = 1'b0; cfg_load_model = 1'($urandom); cfg_n_samples = $urandom;
  endtask

  task automatic send_word(input logic [63:0] d, input int max_gap);
    int t = 0;
    tick($urandom_range(0, max_gap));
    in_valid = 1'b1; in_data = d;
    while (!in_ready && t < 2000) begin tick(1); t++; end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      finish_test();
    end
    tick(1);
    in_valid = 1'b0; in_data = {$urandom, $urandom};
  endtask

  task automatic load_model(input int max_gap);
    logic [63:0] d;
    for (int w = 0; w < MODEL_WORDS; w++) begin
      d = {$urandom, $urandom};
      node_q.push_back({4'(w / N_NODES), 8'(w % N_NODES), d});
      send_word(d, max_gap);
    end
  endtask

  // inject_at >= 0 pulses a stray done after that many feature words
  task automatic run_sample(input logic [31:0] pred, input int max_gap, input int inject_at);
    logic [63:0] d;
    for (int i = 0; i < FEAT_WORDS; i++) begin
      if (i == inject_at) begin
        inj_req++;
        tick(3);
        chk("stray_done_in_ld_feat", out_valid, 0);
      end
      d = {$urandom, $urandom};
      feat_q.push_back({32'(2 * i), d});
      send_word(d, max_gap);
    end
    pred_q.push_back(pred);
    exp_q.push_back(pred);
  endtask

  task automatic wait_job(input int prev);
    int t = 0;
    while (n_job_done == prev && t < 5000) begin tick(1); t++; end
    chk("job_done_count", n_job_done, prev + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int jd;
    int s0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Test 1: model load, one sample
    jd = n_job_done; s0 = n_start;
    send_cfg(1'b1, 1);
    load_model(0);
    run_sample(32'd7, 0, -1);
    wait_job(jd);
    chk("t1_index_wrap", {n_tree, n_node}, 0);
    chk("t1_start_count", n_start - s0, 1);

    // Test 2: three samples, output back-pressure
    ready_pct = 50;
    jd = n_job_done; s0 = n_start;
    send_cfg(1'b0, 3);
    run_sample(32'd3, 1, -1);
    run_sample(32'd9, 1, -1);
    run_sample(32'd0, 1, -1);
    wait_job(jd);
    chk("t2_start_count", n_start - s0, 3);
    ready_pct = 100;
    tick(2);

    // Test 3: empty job
    s0 = n_start;
    send_cfg(1'b0, 0);
    chk("t3_job_done_k1", {job_done, cfg_ready, in_ready}, 3'b000);
    tick(1);
    chk("t3_job_done_k2", {job_done, cfg_ready, in_ready}, 3'b100);
    tick(1);
    chk("t3_job_done_k3", {job_done, cfg_ready, in_ready}, 3'b010);
    chk("t3_no_start", n_start - s0, 0);

    // Test 5: stray done in IDLE and in LD_FEAT
    inj_req++;
    tick(3);
    chk("stray_done_in_idle", out_valid, 0);
    jd = n_job_done;
    send_cfg(1'b0, 1);
    run_sample($urandom, 0, 8);
    wait_job(jd);

    // Test 4: model reload with random input gaps
    jd = n_job_done;
    send_cfg(1'b1, 1);
    load_model(3);
    run_sample($urandom, 2, -1);
    wait_job(jd);
    chk("t4_index_wrap", {n_tree, n_node}, 0);

    // Random jobs
    for (int j = 0; j < 3; j++) begin
      int n;
      n = $urandom_range(1, 3);
      ready_pct = $urandom_range(30, 100);
      jd = n_job_done; s0 = n_start;
      send_cfg(1'b0, n);
      for (int k = 0; k < n; k++) run_sample($urandom, 2, -1);
      wait_job(jd);
      chk("rand_start_count", n_start - s0, n);
    end
    ready_pct = 100;

    // Test 6: reset while waiting for the engine
    eng_hold = 1'b1;
    s0 = n_start;
    send_cfg(1'b0, 1);
    run_sample(32'h1234, 0, -1);
    begin
      int t = 0;
      while (n_start == s0 && t < 100) begin tick(1); t++; end
    end
    chk("t6_start_seen", n_start - s0, 1);
    tick(2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_abort");
    exp_q.delete();
    pred_q.delete();
    eng_hold = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    jd = n_job_done;
    send_cfg(1'b1, 2);
    load_model(0);
    run_sample($urandom, 1, -1);
    run_sample($urandom, 1, -1);
    wait_job(jd);

    tick(5);
    chk("queues_drained", node_q.size() + feat_q.size() + exp_q.size() + pred_q.size(), 0);
    finish_test();
  end

  initial begin
    #(60000 * 10);
    n_fail++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion earlier", cyc);
    finish_test();
  end

endmodule
